pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges the load-use hazard flag, EX branch redirect, a multi-cycle EX op (MUL/DIV) and instruction/data memory wait into one set of per-stage write-enable, flush and bubble controls.
- Sits beside the hazard detection logic and drives the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Also keeps saturating stall and flush performance counters.

Parameters:
- MC_LATENCY, 4, total EX-stage cycles of a multi-cycle op (1..255); 1 means no extra wait.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- load_use_hazard_i  in  1  load in EX whose rd matches rs1/rs2 in ID (1 = stall needed)
- branch_taken_i  in  1  branch/jump resolved taken in EX this cycle
- mc_start_i  in  1  ID/EX holds a multi-cycle op entering EX this cycle
- imem_ready_i  in  1  instruction fetch data valid this cycle
- dmem_req_i  in  1  MEM stage issues a load/store this cycle
- dmem_ready_i  in  1  data memory completes this cycle
- clear_cnt_i  in  1  synchronous clear of both counters
- pc_write_o  out  1  PC register load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID loads a NOP
- id_ex_write_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX loads a bubble (control bits zero)
- ex_mem_bubble_o  out  1  EX/MEM loads a bubble
- mc_done_o  out  1  multi-cycle result valid in EX this cycle
- stall_cycles_o  out  CNT_WIDTH  count of cycles with pc_write_o=0
- flush_count_o  out  CNT_WIDTH  count of branch flush events

Behaviour:
- State register: RUN, MC_WAIT. mc_cnt is 8 bits. run_q is set to 1 on the first clk edge after reset deasserts.
- Reset (reset=0): state=RUN, mc_cnt=0, run_q=0, both counters=0.
  - While run_q=0, outputs are forced: all write enables 0, if_id_flush_o=1, id_ex_flush_o=1, ex_mem_bubble_o=1, mc_done_o=0.
  - Reset asserted mid-operation aborts MC_WAIT immediately.
- Outputs are combinational from the current state and inputs (same-cycle effect). Evaluate in this priority order, highest first:
  1. D-freeze: dmem_req_i & !dmem_ready_i.
     - All write enables 0; all flushes/bubbles 0; mc_done_o 0.
     - No state transition except that mc_cnt still decrements, saturating at 0.
  2. MC_WAIT, or RUN with mc_start_i and MC_LATENCY>1.
     - pc/if_id/id_ex write = 0; ex_mem_bubble_o = 1.
     - On entry from RUN: mc_cnt <= MC_LATENCY-2 and go to MC_WAIT.
     - In MC_WAIT with mc_cnt!=0: decrement.
     - In MC_WAIT with mc_cnt==0: mc_done_o=1, ex_mem_bubble_o=0, all writes 1, return to RUN.
     - branch_taken_i and load_use_hazard_i are ignored while the op has not completed.
  3. branch_taken_i.
     - pc_write_o=1 (redirect); if_id_flush_o=1; id_ex_flush_o=1; flush_count_o increments.
     - Overrides load-use and I-miss.
  4. load_use_hazard_i.
     - pc_write_o=0; if_id_write_o=0; id_ex_flush_o=1; exactly one bubble per hazard cycle.
  5. !imem_ready_i.
     - pc_write_o=0; if_id_flush_o=1; the rest advance.
  6. Otherwise: all write enables 1; all flushes/bubbles 0.
- mc_start_i with MC_LATENCY=1: treated as a normal op; mc_done_o=1 in the same cycle.
- EX occupancy is exactly MC_LATENCY cycles, excluding any D-freeze cycles overlapping the final cycle. Completion waits for D-freeze to clear.
- Counters:
  - stall_cycles_o increments in every run_q=1 cycle with pc_write_o=0.
  - Both counters saturate at all-ones.
  - clear_cnt_i has priority over increment (counter becomes 0).
- A flush request and a clear in the same cycle leave flush_count_o at 0.

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - state enum (RUN, MC_WAIT);
  - the localparam for mc_cnt width (8);
  - a priority-cause encoding (FREEZE, MC, FLUSH, LOAD_USE, IMISS, NONE) used internally and in assertions.
- One sub-module: `sat_counter` (parameter W; inputs clk, reset, clr, inc; output count), instantiated twice.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, all inputs idle, then release -> first cycle after release all flushes=1 and writes=0; next cycle pc/if_id/id_ex write=1; counters=0.
- Load-use: load_use_hazard_i=1 for 1 cycle -> pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1 that cycle; stall_cycles_o=1.
- Branch over load-use: branch_taken_i=1 and load_use_hazard_i=1 together -> pc_write_o=1, if_id_flush_o=1, id_ex_flush_o=1; flush_count_o=1; stall_cycles_o unchanged.
- Multi-cycle op: MC_LATENCY=4, pulse mc_start_i -> 3 cycles frozen with ex_mem_bubble_o=1, then mc_done_o=1 on the 4th cycle; stall_cycles_o=3. A branch_taken_i raised on cycle 2 has no effect.
- D-freeze inside MC_WAIT: dmem_req_i=1, dmem_ready_i=0 for 5 cycles starting at cycle 2 of a 4-cycle op -> all enables 0 and ex_mem_bubble_o=0 during the freeze; mc_done_o=1 on the first cycle after ready returns.
- Saturation/clear with CNT_WIDTH=4:
  - 20 stall cycles -> stall_cycles_o=15.
  - clear_cnt_i=1 while stalling -> 0 on the next cycle.
  - reset=0 mid-MC_WAIT -> state returns to RUN and mc_done_o never asserts.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int MC_CNT_W = 8;

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_FREEZE,
    CAUSE_MC,
    CAUSE_FLUSH,
    CAUSE_LOAD_USE,
    CAUSE_IMISS,
    CAUSE_NONE
  } cause_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges hazard, redirect, multi-cycle
// and memory-wait requests into per-stage pipeline controls.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_use_hazard_i,
  input  logic                 branch_taken_i,
  input  logic                 mc_start_i,
  input  logic                 imem_ready_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  input  logic                 clear_cnt_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_write_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_bubble_o,
  output logic                 mc_done_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  localparam int MC_INIT_I =
    (MC_LATENCY > 1) ? MC_LATENCY - 2 : 0;
  localparam logic [MC_CNT_W-1:0] MC_INIT =
    MC_INIT_I[MC_CNT_W-1:0];
  localparam bit MC_SINGLE = (MC_LATENCY <= 1);

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                run_q, run_d;

  cause_e cause;
  logic   freeze;
  logic   mc_enter;
  logic   mc_fin;

  assign freeze   = dmem_req_i & ~dmem_ready_i;
  assign mc_enter = (state_q == RUN) & mc_start_i & ~MC_SINGLE;
  assign mc_fin   = (state_q == MC_WAIT) & (mc_cnt_q == '0);

  always_comb begin
    cause = CAUSE_NONE;
    if (freeze) begin
      cause = CAUSE_FREEZE;
    end else if ((state_q == MC_WAIT) || mc_enter) begin
      cause = CAUSE_MC;
    end else if (branch_taken_i) begin
      cause = CAUSE_FLUSH;
    end else if (load_use_hazard_i) begin
      cause = CAUSE_LOAD_USE;
    end else if (!imem_ready_i) begin
      cause = CAUSE_IMISS;
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    mc_done_o       = 1'b0;
    if (!run_q) begin
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_bubble_o = 1'b1;
    end else begin
      unique case (cause)
        CAUSE_FREEZE: ;
        CAUSE_MC: begin
          if (mc_fin) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            id_ex_write_o = 1'b1;
            mc_done_o     = 1'b1;
          end else begin
            ex_mem_bubble_o = 1'b1;
          end
        end
        CAUSE_FLUSH: begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_write_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
        CAUSE_LOAD_USE: begin
          id_ex_write_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
        CAUSE_IMISS: begin
          if_id_write_o = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_write_o = 1'b1;
        end
        default: begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
          id_ex_write_o = 1'b1;
        end
      endcase
      // Single-cycle "multi-cycle" ops finish in the cycle they enter EX.
      if (MC_SINGLE && mc_start_i && (cause != CAUSE_FREEZE)) begin
        mc_done_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    run_d    = 1'b1;
    if (run_q) begin
      unique case (cause)
        CAUSE_FREEZE: begin
          if (mc_cnt_q != '0) mc_cnt_d = mc_cnt_q - 1'b1;
        end
        CAUSE_MC: begin
          if (state_q == RUN) begin
            mc_cnt_d = MC_INIT;
            state_d  = MC_WAIT;
          end else if (mc_cnt_q != '0) begin
            mc_cnt_d = mc_cnt_q - 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      run_q    <= run_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_cnt_i),
    .inc   (run_q & ~pc_write_o),
    .count (stall_cycles_o)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_cnt_i),
    .inc   (run_q & (cause == CAUSE_FLUSH)),
    .count (flush_count_o)
  );

  a_done_cause: assert property (
    @(posedge clk) disable iff (!reset)
    mc_done_o |-> ((cause == CAUSE_MC) || MC_SINGLE)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed + random bench for pipeline_stall_controller against
// a cycle-count reference model.
module tb_pipeline_stall_controller;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          lu, br, ms, ir, dq, dr, clr;
  logic          pc_w, ifid_w, ifid_f, idex_w, idex_f, bub, done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  bit m_run  = 0;
  bit m_busy = 0;
  int m_elapsed = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MC_LATENCY (LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .load_use_hazard_i (lu),
    .branch_taken_i    (br),
    .mc_start_i        (ms),
    .imem_ready_i      (ir),
    .dmem_req_i        (dq),
    .dmem_ready_i      (dr),
    .clear_cnt_i       (clr),
    .pc_write_o        (pc_w),
    .if_id_write_o     (ifid_w),
    .if_id_flush_o     (ifid_f),
    .id_ex_write_o     (idex_w),
    .id_ex_flush_o     (idex_f),
    .ex_mem_bubble_o   (bub),
    .mc_done_o         (done),
    .stall_cycles_o    (stall_cnt),
    .flush_count_o     (flush_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h",
               tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, check at negedge, advance model.
  task automatic step(input bit rst_n, input bit i_lu,
                      input bit i_br, input bit i_ms,
                      input bit i_ir, input bit i_dq,
                      input bit i_dr, input bit i_clr);
    bit [6:0] e;
    bit frz;
    reset = rst_n; lu = i_lu; br = i_br; ms = i_ms;
    ir = i_ir; dq = i_dq; dr = i_dr; clr = i_clr;
    if (!rst_n) begin
      m_run = 0; m_busy = 0; m_elapsed = 0;
      m_stall = 0; m_flush = 0;
    end
    @(negedge clk);
    frz = i_dq && !i_dr;
    // order: pc, ifid_w, ifid_f, idex_w, idex_f, bubble, done
    if (!m_run) begin
      e = 7'b0010110;
    end else if (frz) begin
      e = 7'b0000000;
      if (m_busy) m_elapsed++;
    end else if (m_busy || i_ms) begin
      if (m_busy && m_elapsed >= LAT - 1) begin
        e = 7'b1101001;
        m_busy = 0;
      end else begin
        e = 7'b0000010;
        if (!m_busy) begin
          m_busy = 1; m_elapsed = 1;
        end else begin
          m_elapsed++;
        end
      end
    end else if (i_br) begin
      e = 7'b1111100;
    end else if (i_lu) begin
      e = 7'b0001100;
    end else if (!i_ir) begin
      e = 7'b0111000;
    end else begin
      e = 7'b1101000;
    end
    check("ctl", {pc_w, ifid_w, ifid_f, idex_w, idex_f, bub, done},
          {25'd0, e});
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    if (rst_n) begin
      if (i_clr) begin
        m_stall = 0; m_flush = 0;
      end else if (m_run) begin
        if (!e[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (!frz && !(m_busy || e[0]) && i_br && i_ms == 0)
          m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (!frz && e == 7'b1111100)
          m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end
      m_run = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 0; lu = 0; br = 0; ms = 0;
    ir = 1; dq = 0; dr = 0; clr = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    idle(1);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1, 0, 0);
    idle(3);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0,
           $urandom_range(99) < 20,
           $urandom_range(99) < 15,
           $urandom_range(99) < 10,
           $urandom_range(99) < 85,
           $urandom_range(99) < 30,
           $urandom_range(99) < 60,
           $urandom_range(99) < 5);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
